mtime_counter: RTL
==================

# mtime_counter

Free-running 48-bit machine-time counter with programmable prescaler. Sits directly upstream of the machine timer compare block: drives the `mtime` bus that the compare block reads and compares against `mtimecmp`. Exposes a small memory-mapped control region for enable, divider, clear, software load and tear-free 48-bit reads.

## Interface
- `BASE_ADDR`, 32'h40002010: region base; decode on `mem_addr[31:4]`.
- `DIV_W`, 16: prescaler divider width.
- `DIV_RESET`, 0: divider reset value (0 = increment every cycle).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_addr`  in  32  bus address.
- `mem_wdata`  in  32  write data.
- `mem_we`  in  1  write strobe, one cycle per access.
- `mem_re`  in  1  read strobe.
- `mem_rdata`  out  32  read data, combinational; 0 unless `addr_match && mem_re`.
- `stall`  in  1  debug halt; freezes prescaler and counter while high.
- `mtime`  out  48  registered counter value to compare block.
- `tick`  out  1  registered one-cycle pulse, high in the cycle `mtime` shows a newly incremented value.

## Operation
- Offsets (`mem_addr[3:0]`): 0x0 CTRL, 0x4 DIV, 0x8 MTIME_LO, 0xC MTIME_HI; others read 0, writes ignored.
- CTRL: bit0 EN (RW, reset 1); bit1 CLR (W1, self-clearing, reads 0); bit2 OVF (sticky, W1C, reset 0); bits 31:3 read 0.
- DIV: bits `DIV_W-1:0` RW; upper bits read 0. A write also zeroes the prescaler.
- Count: when EN && !stall: if `presc == div` then `presc<=0`, `mtime<=mtime+1`, `tick<=1`; else `presc<=presc+1`. Period = DIV+1 cycles.
- EN=0 or stall=1: presc and mtime hold; tick 0. Resuming continues from the held presc value.
- Wrap: 48'hFFFF_FFFF_FFFF + 1 -> 0; OVF set same edge; tick still pulses.
- CLR write: mtime<=0, presc<=0, tick 0, regardless of EN/stall. Writing CLR together with OVF=1 clears both.
- MTIME_LO write: `mtime[31:0]<=wdata`, presc<=0; MTIME_HI write: `mtime[47:32]<=wdata[15:0]`, presc<=0. The unwritten half holds.
- Tear-free read: reading MTIME_LO returns `mtime[31:0]` and latches `mtime[47:32]` into `hi_snap` on that edge; reading MTIME_HI returns `{16'h0, hi_snap}`. If `mem_re` is held, `hi_snap` re-latches every cycle.
- Simultaneous events:
  - A software write to CTRL.CLR, MTIME_LO/HI or DIV in the same cycle as a terminal count: the write wins, no increment, tick 0.
  - OVF set and an OVF W1C in the same cycle: the set wins.

## Timing
- Reset values: mtime 0, tick 0, presc 0, DIV=`DIV_RESET`, EN 1, OVF 0, hi_snap 0. `mem_rdata` is combinational, so it is 0 while `mem_re` is low.
- Register writes take effect on the edge where `mem_we` is sampled. Readback is visible the next cycle.
- After a DIV=N write at edge t, the first increment occurs at edge t+N+1.
- With DIV=0 and EN, mtime increments every edge starting one edge after reset deassertion, and tick stays high continuously.
- Reset asserted mid-count forces all state to reset values immediately (async). Counting restarts from 0.

## Structure
- Package `mtime_pkg` holds:
  - `MTIME_W=48`;
  - offsets `OFF_CTRL/OFF_DIV/OFF_MTIME_LO/OFF_MTIME_HI`;
  - CTRL bit indices `CTRL_EN/CTRL_CLR/CTRL_OVF`;
  - shared with the compare block for `MTIME_W`.
- One sub-module, `mtime_prescaler`:
  - inputs `div`, `en`, `clr`;
  - output `terminal` pulse, where `terminal` is combinational (`presc == div` and `en`) and presc is held internally.
  - The top level owns mtime, tick, the register file and hi_snap.

## Test plan
- Reset, DIV=0, EN=1 -> mtime = 0,1,2,… on successive edges; tick continuously high after the first edge.
- Write DIV=3 -> increments exactly every 4 cycles, with tick a 1-cycle pulse each time; write EN=0 for 10 cycles -> mtime frozen, tick 0; stall=1 behaves identically.
- Write MTIME_HI=16'hFFFF, MTIME_LO=32'hFFFF_FFFE, DIV=0 -> after 2 increments mtime = 0 and CTRL reads 0x5; write CTRL=0x5 -> CTRL reads 0x1.
- Set mtime=48'h0000_FFFF_FFFF, read MTIME_LO then MTIME_HI across the carry -> LO 32'hFFFF_FFFF and HI 0 (snapshot), not 1.
- MTIME_LO write coinciding with terminal count, DIV=2 -> mtime equals the written value with no +1; next increment 3 cycles later.
- CLR with EN=0 -> mtime 0, presc 0; assert rst_n low mid-count -> mtime 0 and tick 0 immediately, DIV back to `DIV_RESET`.

Source files
------------

// File: rtl/mtime_pkg.sv
// Shared definitions for the machine-time counter and its consumers.
//   MTIME_W       : width of the mtime bus (also used by the compare block)
//   OFF_*         : register offsets within the 16-byte control region
//   CTRL_*        : bit positions inside the CTRL register
package mtime_pkg;

   localparam int unsigned MTIME_W = 48;

   localparam logic [3:0] OFF_CTRL     = 4'h0;
   localparam logic [3:0] OFF_DIV      = 4'h4;
   localparam logic [3:0] OFF_MTIME_LO = 4'h8;
   localparam logic [3:0] OFF_MTIME_HI = 4'hC;

   localparam int unsigned CTRL_EN  = 0;
   localparam int unsigned CTRL_CLR = 1;
   localparam int unsigned CTRL_OVF = 2;

endpackage

// File: rtl/mtime_prescaler.sv
// Prescaler for the machine-time counter.
//   clk, rst_n : clock and asynchronous active-low reset
//   div        : terminal count value (period is div+1 cycles)
//   en         : count enable (EN && !stall); presc holds while low
//   clr        : synchronous zeroing of presc, overrides counting
//   terminal   : combinational, high when en and presc == div
module mtime_prescaler #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] div,
   input  logic             en,
   input  logic             clr,
   output logic             terminal
);

   logic [DIV_W-1:0] presc_q, presc_d;

   assign terminal = en && (presc_q == div);

   always_comb begin
      presc_d = presc_q;
      if (clr) begin
         presc_d = '0;
      end else if (terminal) begin
         presc_d = '0;
      end else if (en) begin
         presc_d = presc_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

endmodule

// File: rtl/mtime_counter.sv
// Free-running 48-bit machine-time counter with programmable prescaler and a
// small memory-mapped control region (CTRL, DIV, MTIME_LO, MTIME_HI).
//   clk, rst_n          : clock and asynchronous active-low reset
//   mem_addr/wdata/we/re: simple single-cycle bus access
//   mem_rdata           : combinational read data, 0 unless selected and read
//   stall               : debug halt, freezes prescaler and counter
//   mtime               : registered counter value to the compare block
//   tick                : one-cycle pulse when mtime shows a new increment
module mtime_counter
   import mtime_pkg::*;
#(
   parameter logic [31:0]      BASE_ADDR = 32'h4000_2010,
   parameter int unsigned      DIV_W     = 16,
   parameter logic [DIV_W-1:0] DIV_RESET = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        mem_addr,
   input  logic [31:0]        mem_wdata,
   input  logic               mem_we,
   input  logic               mem_re,
   output logic [31:0]        mem_rdata,
   input  logic               stall,
   output logic [MTIME_W-1:0] mtime,
   output logic               tick
);

   logic [MTIME_W-1:0] mtime_q, mtime_d;
   logic               tick_q, tick_d;
   logic               en_q, en_d;
   logic               ovf_q, ovf_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [15:0]        hi_snap_q, hi_snap_d;

   logic       addr_match;
   logic [3:0] off;
   logic       wr, rd;
   logic       wr_ctrl, wr_div, wr_lo, wr_hi, wr_clr;
   logic       sw_load;
   logic       terminal;
   logic       inc;
   logic       wrap;

   assign addr_match = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign off        = mem_addr[3:0];
   assign wr         = mem_we && addr_match;
   assign rd         = mem_re && addr_match;

   assign wr_ctrl = wr && (off == OFF_CTRL);
   assign wr_div  = wr && (off == OFF_DIV);
   assign wr_lo   = wr && (off == OFF_MTIME_LO);
   assign wr_hi   = wr && (off == OFF_MTIME_HI);
   assign wr_clr  = wr_ctrl && mem_wdata[CTRL_CLR];

   // Any software update of the count state restarts the prescaler and
   // takes priority over a coinciding terminal count.
   assign sw_load = wr_clr || wr_div || wr_lo || wr_hi;

   mtime_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .div      (div_q),
      .en       (en_q && !stall),
      .clr      (sw_load),
      .terminal (terminal)
   );

   assign inc  = terminal && !sw_load;
   assign wrap = inc && (mtime_q == '1);

   always_comb begin
      mtime_d   = mtime_q;
      tick_d    = inc;
      en_d      = en_q;
      ovf_d     = ovf_q;
      div_d     = div_q;
      hi_snap_d = hi_snap_q;

      if (wr_clr) begin
         mtime_d = '0;
      end else if (wr_lo || wr_hi) begin
         if (wr_lo) mtime_d[31:0]  = mem_wdata;
         if (wr_hi) mtime_d[47:32] = mem_wdata[15:0];
      end else if (inc) begin
         mtime_d = mtime_q + MTIME_W'(1);
      end

      if (wr_ctrl) begin
         en_d = mem_wdata[CTRL_EN];
         if (mem_wdata[CTRL_OVF]) ovf_d = 1'b0;
      end
      // Hardware set beats a same-cycle W1C.
      if (wrap) ovf_d = 1'b1;

      if (wr_div) div_d = mem_wdata[DIV_W-1:0];

      // Reading LO freezes the upper half so a following HI read is tear-free.
      if (rd && (off == OFF_MTIME_LO)) hi_snap_d = mtime_q[47:32];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime_q   <= '0;
         tick_q    <= 1'b0;
         en_q      <= 1'b1;
         ovf_q     <= 1'b0;
         div_q     <= DIV_RESET;
         hi_snap_q <= '0;
      end else begin
         mtime_q   <= mtime_d;
         tick_q    <= tick_d;
         en_q      <= en_d;
         ovf_q     <= ovf_d;
         div_q     <= div_d;
         hi_snap_q <= hi_snap_d;
      end
   end

   always_comb begin
      mem_rdata = '0;
      if (rd) begin
         case (off)
            OFF_CTRL:     mem_rdata = {29'h0, ovf_q, 1'b0, en_q};
            OFF_DIV:      mem_rdata = 32'(div_q);
            OFF_MTIME_LO: mem_rdata = mtime_q[31:0];
            OFF_MTIME_HI: mem_rdata = {16'h0, hi_snap_q};
            default:      mem_rdata = '0;
         endcase
      end
   end

   assign mtime = mtime_q;
   assign tick  = tick_q;

endmodule
